// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with one-shot and auto-reload modes.
// Registers: CTRL (En/Mode/IM), PRESET, COUNT (read-only); irq = irq_flag & IM, registered.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state;
    logic        en;
    logic        im;
    logic [1:0]  mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic ctrl_wr, preset_wr, auto_reload, expire, flag_nxt, im_nxt;
    logic unused_addr;

    assign ctrl_wr     = we && (addr[3:2] == 2'b00);
    assign preset_wr   = we && (addr[3:2] == 2'b01);
    assign auto_reload = (mode == 2'b01);
    assign expire      = (state == CNT) && en && (count <= 32'd1);
    assign im_nxt      = ctrl_wr ? wdata[3] : im;
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    // Expiry set has priority over the clear caused by a CTRL write.
    always_comb begin
        flag_nxt = irq_flag;
        if (ctrl_wr || (state == INT && auto_reload))
            flag_nxt = 1'b0;
        if (expire)
            flag_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            en       <= 1'b0;
            im       <= 1'b0;
            mode     <= 2'b00;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq_flag <= flag_nxt;
            irq      <= flag_nxt & im_nxt;
            case (state)
                IDLE: if (en) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (expire) begin
                        count <= 32'd0;
                        state <= INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        state <= LOAD;
                    end else begin
                        en    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed after the FSM so a CPU CTRL write overrides the one-shot En clear.
            if (ctrl_wr) begin
                en   <= wdata[0];
                mode <= wdata[2:1];
                im   <= wdata[3];
            end
            if (preset_wr)
                preset <= wdata;
        end
    end

    always_comb begin
        case (addr[3:2])
            2'b00:   rdata = {28'd0, im, mode, en};
            2'b01:   rdata = preset;
            2'b10:   rdata = count;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Randomized self-checking bench for timer_counter against a cycle-position model.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    int checks = 0;
    int errors = 0;

    timer_counter dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset;
        reset = 1'b1; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected state k edges after the enabling write: a run is LOAD, N counting
    // cycles, then INT, so its length is max(N,1)+2 edges.
    function automatic void model(input int k, input int n, input bit auto_m,
                                  output logic [31:0] cnt, output bit cnt_ok,
                                  output bit flag, output bit en_e);
        int neff;
        int len;
        int ph;
        neff = (n == 0) ? 1 : n;
        len  = neff + 2;
        cnt  = 32'd0;
        if (!auto_m && k > len) begin
            cnt_ok = 1'b1; flag = 1'b1; en_e = 1'b0;
            return;
        end
        ph     = (k - 1) % len;
        en_e   = 1'b1;
        flag   = (ph == neff + 1);
        cnt_ok = (ph != 0) || (k > len);
        if (ph >= 1 && ph <= neff)
            cnt = (n == 0) ? 32'd0 : 32'(n - (ph - 1));
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(32'h7F00 + 32'(a * 4), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL reset_read off=%0d got %h exp 0", a * 4, d);
            end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    endtask

    task automatic test_rw;
        logic [31:0] d, v;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            v = $urandom() & 32'hFFFF_FFFE;
            wr(32'h7F00, v);
            rd(32'h7F00, d);
            checks++;
            if (d !== {28'd0, v[3:0]}) begin
                errors++; $display("FAIL rw_ctrl got %h exp %h", d, {28'd0, v[3:0]});
            end
            v = $urandom();
            wr(32'h7F04, v);
            rd(32'h7F04, d);
            checks++;
            if (d !== v) begin errors++; $display("FAIL rw_preset got %h exp %h", d, v); end
            wr(32'h7F08, $urandom());
            wr(32'h7F0C, $urandom());
            rd(32'h7F08, d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL rw_count_ro got %h exp 0", d); end
            rd(32'h7F0C, d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL rw_reserved got %h exp 0", d); end
        end
    endtask

    task automatic run_check(input string nm, input int n, input bit auto_m, input bit im,
                             input logic [1:0] md, input int cycles);
        logic [31:0] c, ct, ec;
        bit cok, ef, een;
        for (int k = 1; k <= cycles; k++) begin
            tick();
            rd(32'h7F08, c);
            rd(32'h7F00, ct);
            model(k, n, auto_m, ec, cok, ef, een);
            if (cok) begin
                checks++;
                if (c !== ec) begin
                    errors++; $display("FAIL %s_count n=%0d k=%0d got %0d exp %0d", nm, n, k, c, ec);
                end
            end
            checks++;
            if (irq !== (ef & im)) begin
                errors++; $display("FAIL %s_irq n=%0d k=%0d got %b exp %b", nm, n, k, irq, ef & im);
            end
            checks++;
            if (ct !== {28'd0, im, md, een}) begin
                errors++;
                $display("FAIL %s_ctrl n=%0d k=%0d got %h exp %h", nm, n, k, ct, {28'd0, im, md, een});
            end
        end
    endtask

    task automatic test_oneshot;
        int n;
        bit im;
        logic [1:0] md;
        logic [31:0] d;
        for (int it = 0; it < 5; it++) begin
            n  = (it == 0) ? 5 : $urandom_range(0, 12);
            im = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       md = 2'b00;
                1:       md = 2'b10;
                default: md = 2'b11;
            endcase
            if (it == 0) md = 2'b00;
            do_reset();
            wr(32'h7F04, 32'(n));
            wr(32'h7F00, {28'd0, im, md, 1'b1});
            run_check("oneshot", n, 1'b0, im, md, ((n == 0) ? 1 : n) + 5);
            wr(32'h7F00, 32'h8);
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got %b exp 0", irq); end
            rd(32'h7F00, d);
            checks++;
            if (d !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl_after got %h exp 8", d); end
        end
    endtask

    task automatic test_autoreload;
        int n;
        bit im;
        for (int it = 0; it < 4; it++) begin
            n  = (it == 0) ? 3 : $urandom_range(0, 8);
            im = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            do_reset();
            wr(32'h7F04, 32'(n));
            wr(32'h7F00, {28'd0, im, 2'b01, 1'b1});
            run_check("auto", n, 1'b1, im, 2'b01, 3 * (((n == 0) ? 1 : n) + 2) + 1);
        end
    endtask

    task automatic test_disable;
        logic [31:0] d;
        do_reset();
        wr(32'h7F04, 32'd10);
        wr(32'h7F00, 32'hB);
        for (int k = 1; k <= 5; k++) tick();
        wr(32'h7F00, 32'hA);
        for (int k = 0; k < 3; k++) begin
            rd(32'h7F08, d);
            checks++;
            if (d !== 32'd6) begin errors++; $display("FAIL disable_hold k=%0d got %0d exp 6", k, d); end
            tick();
        end
        wr(32'h7F04, 32'd4);
        wr(32'h7F00, 32'hB);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) begin
                rd(32'h7F08, d);
                checks++;
                if (d !== 32'd4) begin errors++; $display("FAIL disable_reload got %0d exp 4", d); end
            end
            if (k >= 5) begin
                checks++;
                if (irq !== (k == 6)) begin
                    errors++; $display("FAIL disable_irq k=%0d got %b exp %b", k, irq, k == 6);
                end
            end
        end
    endtask

    task automatic test_collision;
        int n;
        logic [31:0] d;
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(1, 6);
            do_reset();
            wr(32'h7F04, 32'(n));
            wr(32'h7F00, 32'h9);
            for (int k = 1; k < n + 2; k++) tick();
            wr(32'h7F00, 32'h9);
            checks++;
            if (irq !== 1'b1) begin errors++; $display("FAIL coll_set_wins got %b exp 1", irq); end
            wr(32'h7F00, 32'h9);
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL coll_int_irq got %b exp 0", irq); end
            rd(32'h7F00, d);
            checks++;
            if (d !== 32'h9) begin errors++; $display("FAIL coll_cpu_wins got %h exp 9", d); end
            tick();
            tick();
            rd(32'h7F08, d);
            checks++;
            if (d !== 32'(n)) begin errors++; $display("FAIL coll_restart got %0d exp %0d", d, n); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        do_reset();
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'hB);
        for (int k = 1; k <= 4; k++) tick();
        rd(32'h7F08, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL mid_pre_count got %0d exp 3", d); end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
        for (int a = 0; a < 4; a++) begin
            rd(32'h7F00 + 32'(a * 4), d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL mid_read off=%0d got %h exp 0", a * 4, d); end
        end
        tick();
        reset = 1'b0;
        wr(32'h7F08, $urandom());
        wr(32'h7F0C, $urandom());
        for (int a = 0; a < 4; a++) begin
            rd(32'h7F00 + 32'(a * 4), d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL mid_after_wr off=%0d got %h exp 0", a * 4, d); end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq_after got %b exp 0", irq); end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        test_reset();
        test_rw();
        test_oneshot();
        test_autoreload();
        test_disable();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
